// File: rtl/count_ctrl.sv
// count_ctrl: command-driven one-shot/periodic up-counter paced by a
// clock-enable prescaler that keeps the whole block on the system clock.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   cmd_valid  command present
//   cmd_ready  command accepted this cycle when high (low only in LOAD)
//   cmd_op     00 STOP, 01 START_ONESHOT, 10 START_PERIODIC, 11 PAUSE_TOGGLE
//   cmd_limit  terminal count, sampled with START_* commands
//   count      current count value
//   busy       high in LOAD, RUN or PAUSE
//   done       one-cycle registered pulse after each terminal tick
//   wrap_cnt   saturating count of periodic wraps since the last START
module count_ctrl #(
   parameter int WIDTH   = 4,
   parameter int PRESC_W = 17,
   parameter int WRAP_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [WIDTH-1:0]  cmd_limit,
   output logic [WIDTH-1:0]  count,
   output logic              busy,
   output logic              done,
   output logic [WRAP_W-1:0] wrap_cnt
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_RUN   = 2'd2,
      S_PAUSE = 2'd3
   } state_e;

   localparam logic [1:0] OP_STOP  = 2'b00;
   localparam logic [1:0] OP_ONE   = 2'b01;
   localparam logic [1:0] OP_PER   = 2'b10;
   localparam logic [1:0] OP_PAUSE = 2'b11;

   state_e state_q;
   state_e state_d;

   logic [WIDTH-1:0]   cnt_q;
   logic [WIDTH-1:0]   limit_q;
   logic [PRESC_W-1:0] presc_q;
   logic [WRAP_W-1:0]  wrap_q;
   logic               per_q;
   logic               done_q;

   logic accept;
   logic start_acc;
   logic stop_acc;
   logic pause_acc;
   logic presc_en;
   logic tick;
   logic at_limit;
   logic wrap_full;

   // Command decode
   assign accept    = cmd_valid & cmd_ready;
   assign start_acc = accept & ((cmd_op == OP_ONE) | (cmd_op == OP_PER));
   assign stop_acc  = accept & (cmd_op == OP_STOP);
   assign pause_acc = accept & (cmd_op == OP_PAUSE);

   // An accepted command wins over a tick in the same cycle: the
   // prescaler does not advance, so a pause never swallows a tick.
   assign tick      = presc_en & (presc_q == {PRESC_W{1'b1}});
   assign at_limit  = (cnt_q == limit_q);
   assign wrap_full = (wrap_q == {WRAP_W{1'b1}});

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (start_acc) state_d = S_LOAD;
         end
         S_LOAD: begin
            state_d = S_RUN;
         end
         S_RUN: begin
            unique case (1'b1)
               start_acc: state_d = S_LOAD;
               stop_acc:  state_d = S_IDLE;
               pause_acc: state_d = S_PAUSE;
               default: begin
                  if (tick && at_limit && !per_q)
                     state_d = S_IDLE;
               end
            endcase
         end
         S_PAUSE: begin
            unique case (1'b1)
               start_acc: state_d = S_LOAD;
               stop_acc:  state_d = S_IDLE;
               pause_acc: state_d = S_RUN;
               default:   state_d = S_PAUSE;
            endcase
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output / control logic
   always_comb begin
      cmd_ready = 1'b1;
      busy      = 1'b1;
      presc_en  = 1'b0;
      unique case (state_q)
         S_IDLE:  busy      = 1'b0;
         S_LOAD:  cmd_ready = 1'b0;
         S_RUN:   presc_en  = ~accept;
         S_PAUSE: presc_en  = 1'b0;
         default: busy      = 1'b0;
      endcase
   end

   // Datapath: START clears count/prescaler/wraps on acceptance so
   // LOAD already presents a zero count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q   <= '0;
         limit_q <= '0;
         presc_q <= '0;
         wrap_q  <= '0;
         per_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= tick & at_limit;
         if (start_acc) begin
            limit_q <= cmd_limit;
            per_q   <= (cmd_op == OP_PER);
            cnt_q   <= '0;
            presc_q <= '0;
            wrap_q  <= '0;
         end else if (stop_acc) begin
            presc_q <= '0;
         end else if (presc_en) begin
            presc_q <= presc_q + PRESC_W'(1);
            if (tick) begin
               if (!at_limit) begin
                  cnt_q <= cnt_q + WIDTH'(1);
               end else if (per_q) begin
                  cnt_q <= '0;
                  if (!wrap_full)
                     wrap_q <= wrap_q + WRAP_W'(1);
               end
            end
         end
      end
   end

   assign count    = cnt_q;
   assign done     = done_q;
   assign wrap_cnt = wrap_q;

endmodule

// File: doc/count_ctrl.md
Name: count_ctrl

Overview:
Command-driven controller that sequences a WIDTH-bit up-counter through one-shot and periodic runs, paced by an internal clock-enable prescaler. The prescaler generates a clock enable rather than a derived clock, so the counter stays on the single system clock. The block sits between a host command source (valid/ready handshake) and any logic that consumes the count value and terminal-count events.

Parameters:
WIDTH, 4, counter width in bits.
PRESC_W, 17, prescaler width; one count tick every 2^PRESC_W clocks while running (benches use 2).
WRAP_W, 8, width of the saturating periodic-wrap counter.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  command can be accepted this cycle.
cmd_op  input  2  00 STOP, 01 START_ONESHOT, 10 START_PERIODIC, 11 PAUSE_TOGGLE.
cmd_limit  input  WIDTH  terminal count; sampled only with START_* commands.
count  output  WIDTH  current count value.
busy  output  1  high in LOAD, RUN or PAUSE.
done  output  1  one-cycle pulse on each terminal count.
wrap_cnt  output  WRAP_W  number of periodic wraps since the last START, saturating.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, count=0, prescaler=0, limit=0, mode=oneshot, done=0, wrap_cnt=0, cmd_ready=1.
- Handshake: a command is accepted on a rising edge when cmd_valid=1 and cmd_ready=1.
  - cmd_ready=0 only in LOAD.
  - cmd_op and cmd_limit must be held stable while cmd_valid=1 and cmd_ready=0.
- FSM states: IDLE, LOAD, RUN, PAUSE.
- START_* accepted (any state):
  - next state LOAD; latch limit and mode.
  - In LOAD: count=0, prescaler=0, wrap_cnt=0. LOAD lasts exactly 1 cycle, then RUN.
- RUN:
  - prescaler increments every clock and wraps at its maximum.
  - tick = (prescaler == 2^PRESC_W-1) in RUN; first tick occurs 2^PRESC_W clocks after entering RUN.
  - On a tick with count != limit: count <= count+1.
  - On a tick with count == limit:
    - oneshot: done pulses next cycle; count holds limit; go to IDLE.
    - periodic: count <= 0; done pulses next cycle; wrap_cnt increments, saturating at all-ones; stay in RUN.
- limit=0:
  - oneshot completes at the first tick with count=0.
  - periodic pulses done on every tick; count stays 0.
- PAUSE_TOGGLE:
  - RUN -> PAUSE: prescaler and count frozen.
  - PAUSE -> RUN: resumes from the frozen prescaler value, with no lost or extra ticks.
  - In IDLE: accepted, no effect.
- STOP (any state except LOAD): next state IDLE; count holds its current value; prescaler cleared; no done pulse; wrap_cnt holds.
- Simultaneous command acceptance and tick: the command wins and the tick is discarded (no increment, no done).
- done is registered: high exactly 1 cycle, the cycle after the terminal tick edge. It is never high in LOAD.
- Reset mid-run: immediate return to reset values; no done pulse is generated.
- All arithmetic is unsigned modulo field width, except wrap_cnt, which saturates.

Test Plan (PRESC_W=2, WIDTH=4):
- Reset then idle: hold rst=0 3 cycles, release -> count=0, busy=0, done=0, cmd_ready=1, wrap_cnt=0; count stays 0 for 20 cycles.
- One-shot: START_ONESHOT with limit=3 -> cmd_ready=0 for 1 cycle; count steps 0,1,2,3 every 4 clocks; done pulses once for 1 cycle after the tick at count=3; busy drops; count holds 3.
- Periodic with saturation: START_PERIODIC with limit=1, WRAP_W=2 -> count sequence 0,1,0,1,...; done pulses every 8 clocks; wrap_cnt goes 1,2,3 and stays 3.
- Pause/resume: during a one-shot with limit=5, PAUSE_TOGGLE at count=2 -> count and prescaler frozen for 10 cycles, busy=1; second toggle -> next increment arrives exactly the remaining prescaler cycles later; run finishes at count 5.
- STOP and restart collisions:
  - STOP issued on a tick cycle at count=4 -> IDLE, count=4, no done.
  - START_ONESHOT with limit=0 issued while RUN -> restart via LOAD; done after 4 clocks of RUN.
- Async reset mid-run: drive rst=0 between clock edges at count=6 -> outputs clear immediately, without waiting for an edge; no done.
